ccip_hazard_tracker: RTL and testbench
======================================

Name: ccip_hazard_tracker

Overview:
Parametrised outstanding-request tracker and memory-hazard detector for the CCI-P AFU boundary in ASE. It records every C0 read and C1 write request in a tag-indexed table of NUM_ENTRIES entries, and retires each entry on its matching response. Each new request is checked against all in-flight addresses to classify RAR/RAW/WAR/WAW hazards. It also reports overflow, orphan-response and duplicate-tag errors, and occupancy statistics, to the ASE warning logger.

Parameters:
NUM_ENTRIES, 32, table depth (max outstanding requests, reads and writes combined); power of two >= 2
ADDR_WIDTH, 42, cache-line address width
TAG_WIDTH, 16, mdata tag width
HAZARD_MASK, 4'b1110, per-type enable {WAW,WAR,RAW,RAR} (bit3..bit0)
CNT_WIDTH, 16, hazard counter width

Ports:
clk  in  1  clock
sys_reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear of sticky errors, hazard_cnt and peak_cnt; table untouched
c0tx_valid  in  1  read request issued
c0tx_addr  in  ADDR_WIDTH  read cache-line address
c0tx_tag  in  TAG_WIDTH  read mdata
c1tx_valid  in  1  write request issued
c1tx_addr  in  ADDR_WIDTH  write cache-line address
c1tx_tag  in  TAG_WIDTH  write mdata
c0rx_valid  in  1  read response
c0rx_tag  in  TAG_WIDTH  read response mdata
c1rx_valid  in  1  write response
c1rx_tag  in  TAG_WIDTH  write response mdata
hazard_valid  out  1  hazard detected (one-cycle pulse)
hazard_type  out  4  one-hot {WAW,WAR,RAW,RAR}
hazard_addr  out  ADDR_WIDTH  offending address
hazard_ch  out  1  0=C0 request, 1=C1 request
err_overflow  out  1  sticky: request arrived with no free entry
err_orphan  out  1  sticky: response with no matching entry
err_dup_tag  out  1  sticky: request tag already outstanding on the same channel
outstanding_cnt  out  $clog2(NUM_ENTRIES+1)  valid entries
peak_cnt  out  $clog2(NUM_ENTRIES+1)  high-water mark of outstanding_cnt
hazard_cnt  out  CNT_WIDTH  saturating count of reported hazards

Behaviour:
- Reset: all entries invalid. Every output is 0.
- Entry fields: valid, is_write, addr, tag.
- Every lookup in cycle N uses the table state at the start of cycle N. All outputs are registered, so effects are visible at cycle N+1.
- Retire: a c0rx_valid tag matches a valid read entry with equal tag; a c1rx_valid tag matches a valid write entry with equal tag. A match clears that entry. No match sets err_orphan. An entry allocated in the same cycle is never matched.
- Hazard classification for a new request vs a valid entry with equal addr, or vs the same-cycle C0 request: read-vs-read=RAR, read-after-write=RAW, write-after-read=WAR, write-after-write=WAW. A type is reported only if its HAZARD_MASK bit is set. Entries being retired in the same cycle still participate in hazard checks.
- Intra-cycle ordering: C0 is treated as issued before C1. If both are valid with equal addr, C1 additionally sees C0 as in-flight; C1 write vs C0 read = WAR.
- Multiple matches for one request: hazard_type is the OR of all matched types, and that request counts as one hazard.
- Both channels hazard in the same cycle: hazard_valid=1, hazard_ch=0 and hazard_addr=c0tx_addr. hazard_cnt increases by 2.
- hazard_cnt saturates at all-ones.
- Allocation: C0 takes the lowest-index free entry and C1 the next-lowest. Only entries free at the start of the cycle are eligible. With one free entry, C0 gets it, C1 is dropped and err_overflow is set.
- Dup tag: a request whose tag matches a valid entry on the same channel (and not retired this cycle) is not recorded and sets err_dup_tag. It is still hazard-checked.
- Overflow: a dropped request is still hazard-checked and is not counted in outstanding_cnt.
- outstanding_cnt = next-state count of valid entries (range 0..NUM_ENTRIES).
- peak_cnt = max(peak_cnt, outstanding_cnt next).
- clear: clears err_*, hazard_cnt and peak_cnt. If clear coincides with a new event, the new event wins: sticky flag set, counter = the increment only, peak_cnt = current outstanding.
- Reset mid-operation: table dropped immediately and asynchronously. Responses arriving after reset release are orphans.

Test Plan:
- Read addr 0x100 tag 1, then read 0x100 tag 2 (default mask) -> hazard_valid=0, outstanding_cnt=2; responses tags 1,2 -> outstanding_cnt=0, no errors.
- Write 0x200 tag 5, next cycle read 0x200 tag 6 -> hazard_valid=1, hazard_type=4'b0010 (RAW), hazard_ch=0, hazard_cnt=1.
- Same cycle read 0x300 tag 7 + write 0x300 tag 7 -> hazard_type=4'b0100 (WAR), hazard_ch=1. No dup_tag, because the tags are on different channels.
- Fill NUM_ENTRIES=32 reads, then issue a 33rd -> err_overflow=1, outstanding_cnt=32, peak_cnt=32. Then clear -> err_overflow=0, peak_cnt=32.
- c1rx_valid tag 9 with nothing outstanding -> err_orphan=1. Read tag 3 followed by another read tag 3 -> err_dup_tag=1, outstanding_cnt=1.
- Assert sys_reset with 10 entries outstanding -> all outputs 0 immediately. After release, a response with tag 0 -> err_orphan=1.

Source files
------------

// File: rtl/ccip_hazard_tracker.sv
// Tag-indexed outstanding-request table for CCI-P C0 reads / C1 writes with RAR/RAW/WAR/WAW hazard classification.
// All outputs registered (1-cycle latency); no backpressure: requests finding no free entry are dropped and flagged.
module ccip_hazard_tracker #(
  parameter int         NUM_ENTRIES = 32,
  parameter int         ADDR_WIDTH  = 42,
  parameter int         TAG_WIDTH   = 16,
  parameter logic [3:0] HAZARD_MASK = 4'b1110,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             sys_reset,
  input  logic                             clear,
  input  logic                             c0tx_valid,
  input  logic [ADDR_WIDTH-1:0]            c0tx_addr,
  input  logic [TAG_WIDTH-1:0]             c0tx_tag,
  input  logic                             c1tx_valid,
  input  logic [ADDR_WIDTH-1:0]            c1tx_addr,
  input  logic [TAG_WIDTH-1:0]             c1tx_tag,
  input  logic                             c0rx_valid,
  input  logic [TAG_WIDTH-1:0]             c0rx_tag,
  input  logic                             c1rx_valid,
  input  logic [TAG_WIDTH-1:0]             c1rx_tag,
  output logic                             hazard_valid,
  output logic [3:0]                       hazard_type,
  output logic [ADDR_WIDTH-1:0]            hazard_addr,
  output logic                             hazard_ch,
  output logic                             err_overflow,
  output logic                             err_orphan,
  output logic                             err_dup_tag,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] outstanding_cnt,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] peak_cnt,
  output logic [CNT_WIDTH-1:0]             hazard_cnt
);
  localparam int OCW = $clog2(NUM_ENTRIES + 1);
  localparam int IW  = $clog2(NUM_ENTRIES);
  localparam int CW1 = CNT_WIDTH + 1;
  localparam int RAR = 0;
  localparam int RAW = 1;
  localparam int WAR = 2;
  localparam int WAW = 3;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d, is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q [NUM_ENTRIES];
  logic [ADDR_WIDTH-1:0]  addr_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag_q  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag_d  [NUM_ENTRIES];

  logic                  hazard_valid_q, hazard_valid_d;
  logic [3:0]            hazard_type_q, hazard_type_d;
  logic [ADDR_WIDTH-1:0] hazard_addr_q, hazard_addr_d;
  logic                  hazard_ch_q, hazard_ch_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_orphan_q, err_orphan_d;
  logic                  err_dup_tag_q, err_dup_tag_d;
  logic [OCW-1:0]        outstanding_cnt_q, outstanding_cnt_d;
  logic [OCW-1:0]        peak_cnt_q, peak_cnt_d;
  logic [CNT_WIDTH-1:0]  hazard_cnt_q, hazard_cnt_d;

  logic [NUM_ENTRIES-1:0] ret_mask;
  logic                   c0_hit, c1_hit, c0_dup, c1_dup;
  logic [3:0]             c0_type, c1_type;
  logic                   c0_haz, c1_haz;

  // Lookups against the table as it stood at the start of the cycle.
  always_comb begin
    ret_mask = '0;
    c0_hit   = 1'b0;
    c1_hit   = 1'b0;
    c0_dup   = 1'b0;
    c1_dup   = 1'b0;
    c0_type  = '0;
    c1_type  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i]) begin
        if (c0rx_valid && !is_wr_q[i] && tag_q[i] == c0rx_tag) begin
          ret_mask[i] = 1'b1;
          c0_hit      = 1'b1;
        end
        if (c1rx_valid && is_wr_q[i] && tag_q[i] == c1rx_tag) begin
          ret_mask[i] = 1'b1;
          c1_hit      = 1'b1;
        end
        if (addr_q[i] == c0tx_addr) begin
          if (is_wr_q[i]) c0_type[RAW] = 1'b1;
          else            c0_type[RAR] = 1'b1;
        end
        if (addr_q[i] == c1tx_addr) begin
          if (is_wr_q[i]) c1_type[WAW] = 1'b1;
          else            c1_type[WAR] = 1'b1;
        end
        if (!ret_mask[i] && !is_wr_q[i] && tag_q[i] == c0tx_tag) c0_dup = 1'b1;
        if (!ret_mask[i] && is_wr_q[i] && tag_q[i] == c1tx_tag)  c1_dup = 1'b1;
      end
    end
    // C0 is ordered ahead of C1, so a same-cycle read is already in flight for the write.
    if (c0tx_valid && c0tx_addr == c1tx_addr) c1_type[WAR] = 1'b1;
    c0_type = c0tx_valid ? (c0_type & HAZARD_MASK) : 4'b0000;
    c1_type = c1tx_valid ? (c1_type & HAZARD_MASK) : 4'b0000;
    c0_dup  = c0_dup & c0tx_valid;
    c1_dup  = c1_dup & c1tx_valid;
    c0_haz  = |c0_type;
    c1_haz  = |c1_type;
  end

  logic          free0_found, free1_found;
  logic [IW-1:0] free0_idx, free1_idx, c1_idx;
  logic          c0_req, c1_req, c0_alloc, c1_alloc;
  logic [1:0]    haz_inc;
  logic [CW1-1:0] hcnt_sum;
  logic [OCW-1:0] peak_base;

  always_comb begin
    free0_found = 1'b0;
    free1_found = 1'b0;
    free0_idx   = '0;
    free1_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_q[i]) begin
        if (!free0_found) begin
          free0_found = 1'b1;
          free0_idx   = IW'(i);
        end else if (!free1_found) begin
          free1_found = 1'b1;
          free1_idx   = IW'(i);
        end
      end
    end

    c0_req   = c0tx_valid && !c0_dup;
    c1_req   = c1tx_valid && !c1_dup;
    c0_alloc = c0_req && free0_found;
    c1_alloc = c1_req && (c0_alloc ? free1_found : free0_found);
    c1_idx   = c0_alloc ? free1_idx : free0_idx;

    valid_d = valid_q & ~ret_mask;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    if (c0_alloc) begin
      valid_d[free0_idx] = 1'b1;
      is_wr_d[free0_idx] = 1'b0;
      addr_d[free0_idx]  = c0tx_addr;
      tag_d[free0_idx]   = c0tx_tag;
    end
    if (c1_alloc) begin
      valid_d[c1_idx] = 1'b1;
      is_wr_d[c1_idx] = 1'b1;
      addr_d[c1_idx]  = c1tx_addr;
      tag_d[c1_idx]   = c1tx_tag;
    end

    outstanding_cnt_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      outstanding_cnt_d = outstanding_cnt_d + OCW'(valid_d[i]);
    end

    // Clear only wipes history; events in the clearing cycle still land.
    peak_base  = clear ? '0 : peak_cnt_q;
    peak_cnt_d = (outstanding_cnt_d > peak_base) ? outstanding_cnt_d : peak_base;

    err_overflow_d = (clear ? 1'b0 : err_overflow_q) |
                     (c0_req && !c0_alloc) | (c1_req && !c1_alloc);
    err_orphan_d   = (clear ? 1'b0 : err_orphan_q) |
                     (c0rx_valid && !c0_hit) | (c1rx_valid && !c1_hit);
    err_dup_tag_d  = (clear ? 1'b0 : err_dup_tag_q) | c0_dup | c1_dup;

    hazard_valid_d = c0_haz | c1_haz;
    hazard_type_d  = c0_haz ? c0_type : c1_type;
    hazard_addr_d  = c0_haz ? c0tx_addr : (c1_haz ? c1tx_addr : '0);
    hazard_ch_d    = !c0_haz && c1_haz;
    haz_inc        = {1'b0, c0_haz} + {1'b0, c1_haz};
    hcnt_sum       = {1'b0, (clear ? '0 : hazard_cnt_q)} + CW1'(haz_inc);
    hazard_cnt_d   = hcnt_sum[CNT_WIDTH] ? '1 : hcnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      valid_q           <= '0;
      is_wr_q           <= '0;
      addr_q            <= '{default: '0};
      tag_q             <= '{default: '0};
      hazard_valid_q    <= 1'b0;
      hazard_type_q     <= '0;
      hazard_addr_q     <= '0;
      hazard_ch_q       <= 1'b0;
      err_overflow_q    <= 1'b0;
      err_orphan_q      <= 1'b0;
      err_dup_tag_q     <= 1'b0;
      outstanding_cnt_q <= '0;
      peak_cnt_q        <= '0;
      hazard_cnt_q      <= '0;
    end else begin
      valid_q           <= valid_d;
      is_wr_q           <= is_wr_d;
      addr_q            <= addr_d;
      tag_q             <= tag_d;
      hazard_valid_q    <= hazard_valid_d;
      hazard_type_q     <= hazard_type_d;
      hazard_addr_q     <= hazard_addr_d;
      hazard_ch_q       <= hazard_ch_d;
      err_overflow_q    <= err_overflow_d;
      err_orphan_q      <= err_orphan_d;
      err_dup_tag_q     <= err_dup_tag_d;
      outstanding_cnt_q <= outstanding_cnt_d;
      peak_cnt_q        <= peak_cnt_d;
      hazard_cnt_q      <= hazard_cnt_d;
    end
  end

  assign hazard_valid    = hazard_valid_q;
  assign hazard_type     = hazard_type_q;
  assign hazard_addr     = hazard_addr_q;
  assign hazard_ch       = hazard_ch_q;
  assign err_overflow    = err_overflow_q;
  assign err_orphan      = err_orphan_q;
  assign err_dup_tag     = err_dup_tag_q;
  assign outstanding_cnt = outstanding_cnt_q;
  assign peak_cnt        = peak_cnt_q;
  assign hazard_cnt      = hazard_cnt_q;

endmodule

// File: tb/tb_ccip_hazard_tracker.sv
// Bench for ccip_hazard_tracker: directed vector table, hand-written overflow/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_ccip_hazard_tracker;
  localparam int N  = 32;
  localparam int AW = 42;
  localparam int TW = 16;
  localparam int CW = 4;
  localparam int OW = $clog2(N + 1);
  localparam logic [3:0] MASK = 4'b1110;
  localparam int RAW_T = 2;
  localparam int WAR_T = 4;
  localparam int E_OVF = 1;
  localparam int E_ORP = 2;
  localparam int E_DUP = 4;

  logic clk = 1'b0;
  logic sys_reset, clear;
  logic c0tx_valid, c1tx_valid, c0rx_valid, c1rx_valid;
  logic [AW-1:0] c0tx_addr, c1tx_addr;
  logic [TW-1:0] c0tx_tag, c1tx_tag, c0rx_tag, c1rx_tag;
  logic hazard_valid, hazard_ch, err_overflow, err_orphan, err_dup_tag;
  logic [3:0] hazard_type;
  logic [AW-1:0] hazard_addr;
  logic [OW-1:0] outstanding_cnt, peak_cnt;
  logic [CW-1:0] hazard_cnt;

  ccip_hazard_tracker #(
    .NUM_ENTRIES(N), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .HAZARD_MASK(MASK), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .sys_reset(sys_reset), .clear(clear),
    .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_tag(c0tx_tag),
    .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_tag(c1tx_tag),
    .c0rx_valid(c0rx_valid), .c0rx_tag(c0rx_tag),
    .c1rx_valid(c1rx_valid), .c1rx_tag(c1rx_tag),
    .hazard_valid(hazard_valid), .hazard_type(hazard_type), .hazard_addr(hazard_addr),
    .hazard_ch(hazard_ch), .err_overflow(err_overflow), .err_orphan(err_orphan),
    .err_dup_tag(err_dup_tag), .outstanding_cnt(outstanding_cnt), .peak_cnt(peak_cnt),
    .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic c0v; logic [AW-1:0] c0a; logic [TW-1:0] c0t;
    logic c1v; logic [AW-1:0] c1a; logic [TW-1:0] c1t;
    logic r0v; logic [TW-1:0] r0t;
    logic r1v; logic [TW-1:0] r1t;
    logic clr;
  } stim_t;

  // err packs {dup, orphan, overflow}
  typedef struct packed {
    logic hv; logic [3:0] ty; logic ch; logic [AW-1:0] ha;
    logic [2:0] err; logic [OW-1:0] out; logic [OW-1:0] peak; logic [CW-1:0] hcnt;
  } exp_t;

  typedef struct packed { stim_t s; exp_t e; } vec_t;

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [TW-1:0] tag; } ent_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  ent_t mq[$];
  int m_err, m_hcnt, m_peak;

  function automatic stim_t mk_s(int c0v, int c0a, int c0t, int c1v, int c1a, int c1t,
                                 int r0v, int r0t, int r1v, int r1t, int clr);
    stim_t s;
    s.c0v = (c0v != 0); s.c0a = AW'(c0a); s.c0t = TW'(c0t);
    s.c1v = (c1v != 0); s.c1a = AW'(c1a); s.c1t = TW'(c1t);
    s.r0v = (r0v != 0); s.r0t = TW'(r0t);
    s.r1v = (r1v != 0); s.r1t = TW'(r1t);
    s.clr = (clr != 0);
    return s;
  endfunction

  function automatic exp_t mk_e(int hv, int ty, int ch, int ha, int err, int out, int peak, int hcnt);
    exp_t e;
    e.hv = (hv != 0); e.ty = 4'(ty); e.ch = (ch != 0); e.ha = AW'(ha);
    e.err = 3'(err); e.out = OW'(out); e.peak = OW'(peak); e.hcnt = CW'(hcnt);
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    c0tx_valid = s.c0v; c0tx_addr = s.c0a; c0tx_tag = s.c0t;
    c1tx_valid = s.c1v; c1tx_addr = s.c1a; c1tx_tag = s.c1t;
    c0rx_valid = s.r0v; c0rx_tag = s.r0t;
    c1rx_valid = s.r1v; c1rx_tag = s.r1t;
    clear = s.clr;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    drive('0);
  endtask

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a.hv = hazard_valid; a.ty = hazard_type; a.ch = hazard_ch; a.ha = hazard_addr;
    a.err = {err_dup_tag, err_orphan, err_overflow};
    a.out = outstanding_cnt; a.peak = peak_cnt; a.hcnt = hazard_cnt;
    checks++;
    // hazard detail fields carry no meaning while no hazard is reported
    if (!e.hv && !a.hv) begin
      a.ty = e.ty; a.ch = e.ch; a.ha = e.ha;
    end
    if (a !== e) begin
      failures++;
      $display("FAIL %s: actual hv=%0b ty=%b ch=%0b addr=%h err=%b out=%0d peak=%0d hcnt=%0d ; required hv=%0b ty=%b ch=%0b addr=%h err=%b out=%0d peak=%0d hcnt=%0d",
               nm, a.hv, a.ty, a.ch, a.ha, a.err, a.out, a.peak, a.hcnt,
               e.hv, e.ty, e.ch, e.ha, e.err, e.out, e.peak, e.hcnt);
    end
  endtask

  task automatic do_reset();
    drive('0);
    sys_reset = 1'b1;
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    mq.delete();
    m_err = 0; m_hcnt = 0; m_peak = 0;
  endtask

  // Reference: outstanding requests as an unordered bag; slot positions are invisible outside.
  task automatic model_step(input stim_t s, output exp_t e);
    ent_t keep[$];
    ent_t ne;
    logic [3:0] t0, t1;
    bit hit0, hit1, dup0, dup1, ovf, gone;
    int room, inc, sum;
    t0 = '0; t1 = '0;
    hit0 = 0; hit1 = 0; dup0 = 0; dup1 = 0; ovf = 0;
    room = N - mq.size();
    foreach (mq[i]) begin
      gone = (s.r0v && !mq[i].wr && mq[i].tag == s.r0t) || (s.r1v && mq[i].wr && mq[i].tag == s.r1t);
      if (gone && mq[i].wr) hit1 = 1;
      if (gone && !mq[i].wr) hit0 = 1;
      if (s.c0v && mq[i].addr == s.c0a) t0 |= mq[i].wr ? 4'b0010 : 4'b0001;
      if (s.c1v && mq[i].addr == s.c1a) t1 |= mq[i].wr ? 4'b1000 : 4'b0100;
      if (!gone && s.c0v && !mq[i].wr && mq[i].tag == s.c0t) dup0 = 1;
      if (!gone && s.c1v && mq[i].wr && mq[i].tag == s.c1t) dup1 = 1;
      if (!gone) keep.push_back(mq[i]);
    end
    if (s.c0v && s.c1v && s.c0a == s.c1a) t1 |= 4'b0100;
    t0 &= MASK;
    t1 &= MASK;
    if (s.c0v && !dup0) begin
      if (room > 0) begin
        ne.wr = 1'b0; ne.addr = s.c0a; ne.tag = s.c0t;
        keep.push_back(ne);
        room--;
      end else ovf = 1;
    end
    if (s.c1v && !dup1) begin
      if (room > 0) begin
        ne.wr = 1'b1; ne.addr = s.c1a; ne.tag = s.c1t;
        keep.push_back(ne);
        room--;
      end else ovf = 1;
    end
    mq = keep;
    if (s.clr) begin
      m_err = 0; m_hcnt = 0; m_peak = 0;
    end
    if ((s.r0v && !hit0) || (s.r1v && !hit1)) m_err |= E_ORP;
    if (dup0 || dup1) m_err |= E_DUP;
    if (ovf) m_err |= E_OVF;
    inc = int'(t0 != 0) + int'(t1 != 0);
    sum = m_hcnt + inc;
    m_hcnt = (sum > (1 << CW) - 1) ? (1 << CW) - 1 : sum;
    if (mq.size() > m_peak) m_peak = mq.size();
    e.hv   = (t0 != 0) || (t1 != 0);
    e.ty   = (t0 != 0) ? t0 : t1;
    e.ch   = (t0 == 0) && (t1 != 0);
    e.ha   = (t0 != 0) ? s.c0a : ((t1 != 0) ? s.c1a : '0);
    e.err  = 3'(m_err);
    e.out  = OW'(mq.size());
    e.peak = OW'(m_peak);
    e.hcnt = CW'(m_hcnt);
  endtask

  function automatic logic [TW-1:0] pick_tag(input bit wr);
    logic [TW-1:0] pool[$];
    foreach (mq[i]) if (mq[i].wr == wr) pool.push_back(mq[i].tag);
    if (pool.size() > 0 && $urandom_range(0, 7) != 0)
      return pool[$urandom_range(0, pool.size() - 1)];
    return TW'($urandom_range(0, 23));
  endfunction

  initial begin
    stim_t s;
    exp_t e;
    sys_reset = 1'b0;
    drive('0);
    do_reset();
    check("reset_state", mk_e(0, 0, 0, 0, 0, 0, 0, 0));

    //      c0v c0a    c0t c1v c1a   c1t r0v r0t r1v r1t clr      hv ty    ch ha     err          out peak hcnt
    add(mk_s(1, 'h100, 1,  0, 0,     0,  0, 0,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           1, 1, 0));
    add(mk_s(1, 'h100, 2,  0, 0,     0,  0, 0,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           2, 2, 0));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 1,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           1, 2, 0));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 2,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           0, 2, 0));
    add(mk_s(0, 0,     0,  1, 'h200, 5,  0, 0,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           1, 2, 0));
    add(mk_s(1, 'h200, 6,  0, 0,     0,  0, 0,  0, 0,  0), mk_e(1, RAW_T, 0, 'h200, 0,           2, 2, 1));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 6,  1, 5,  0), mk_e(0, 0,     0, 0,     0,           0, 2, 1));
    add(mk_s(1, 'h300, 7,  1, 'h300, 7,  0, 0,  0, 0,  0), mk_e(1, WAR_T, 1, 'h300, 0,           2, 2, 2));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 7,  1, 7,  0), mk_e(0, 0,     0, 0,     0,           0, 2, 2));
    add(mk_s(0, 0,     0,  0, 0,     0,  0, 0,  1, 9,  0), mk_e(0, 0,     0, 0,     E_ORP,       0, 2, 2));
    add(mk_s(1, 'h400, 3,  0, 0,     0,  0, 0,  0, 0,  0), mk_e(0, 0,     0, 0,     E_ORP,       1, 2, 2));
    add(mk_s(1, 'h400, 3,  0, 0,     0,  0, 0,  0, 0,  0), mk_e(0, 0,     0, 0,     E_ORP|E_DUP, 1, 2, 2));
    add(mk_s(0, 0,     0,  1, 'h400, 4,  0, 0,  0, 0,  0), mk_e(1, WAR_T, 1, 'h400, E_ORP|E_DUP, 2, 2, 3));
    add(mk_s(1, 'h400, 5,  0, 0,     0,  0, 0,  0, 0,  1), mk_e(1, RAW_T, 0, 'h400, 0,           3, 3, 1));
    add(mk_s(1, 'h400, 6,  1, 'h400, 7,  0, 0,  0, 0,  0), mk_e(1, RAW_T, 0, 'h400, 0,           5, 5, 3));
    add(mk_s(1, 'h400, 3,  0, 0,     0,  1, 3,  1, 4,  0), mk_e(1, RAW_T, 0, 'h400, 0,           4, 5, 4));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 3,  1, 7,  0), mk_e(0, 0,     0, 0,     0,           2, 5, 4));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 5,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           1, 5, 4));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 6,  0, 0,  0), mk_e(0, 0,     0, 0,     0,           0, 5, 4));
    add(mk_s(1, 'h500, 10, 0, 0,     0,  1, 10, 0, 0,  0), mk_e(0, 0,     0, 0,     E_ORP,       1, 5, 4));
    add(mk_s(0, 0,     0,  0, 0,     0,  1, 10, 0, 0,  0), mk_e(0, 0,     0, 0,     E_ORP,       0, 5, 4));
    add(mk_s(0, 0,     0,  0, 0,     0,  0, 0,  0, 0,  1), mk_e(0, 0,     0, 0,     0,           0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].e);
    end

    // fill the table, then overflow it
    for (int i = 0; i < N; i++) step(mk_s(1, 'h1000 + i, 100 + i, 0, 0, 0, 0, 0, 0, 0, 0));
    check("fill_full", mk_e(0, 0, 0, 0, 0, N, N, 0));
    step(mk_s(1, 'h2000, 200, 0, 0, 0, 0, 0, 0, 0, 0));
    check("overflow", mk_e(0, 0, 0, 0, E_OVF, N, N, 0));
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("overflow_clear", mk_e(0, 0, 0, 0, 0, N, N, 0));
    step(mk_s(0, 0, 0, 0, 0, 0, 1, 100, 0, 0, 0));
    check("retire_one", mk_e(0, 0, 0, 0, 0, N - 1, N, 0));
    step(mk_s(1, 'h3000, 300, 1, 'h3001, 301, 0, 0, 0, 0, 0));
    check("one_free_c1_drop", mk_e(0, 0, 0, 0, E_OVF, N, N, 0));

    // asynchronous reset with traffic in flight
    do_reset();
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
    for (int i = 0; i < 9; i++) step(mk_s(1, 'h700, i, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk_s(0, 0, 0, 1, 'h700, 50, 0, 0, 0, 0, 0));
    check("pre_reset", mk_e(1, WAR_T, 1, 'h700, E_ORP, 10, 10, 1));
    #2 sys_reset = 1'b1;
    #1 check("async_reset", mk_e(0, 0, 0, 0, 0, 0, 0, 0));
    #2 sys_reset = 1'b0;
    step(mk_s(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    check("orphan_after_reset", mk_e(0, 0, 0, 0, E_ORP, 0, 0, 0));

    // randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = '0;
      s.c0v = ($urandom_range(0, 1) == 1);
      s.c0a = AW'('h40 + $urandom_range(0, 5));
      s.c0t = TW'($urandom_range(0, 23));
      s.c1v = ($urandom_range(0, 2) == 0);
      s.c1a = AW'('h40 + $urandom_range(0, 5));
      s.c1t = TW'($urandom_range(0, 23));
      s.r0v = ($urandom_range(0, 1) == 1);
      s.r0t = pick_tag(1'b0);
      s.r1v = ($urandom_range(0, 2) == 0);
      s.r1t = pick_tag(1'b1);
      s.clr = ($urandom_range(0, 15) == 0);
      model_step(s, e);
      step(s);
      check($sformatf("rand%0d", cyc), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
